// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared writeback-stage types and widths. Provides the
//                datapath width, the register-address width, the writeback
//                arbiter state encoding and the {rd, data} request record
//                that is carried through the load-result FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  // Writeback arbiter states: NORMAL lets the ALU win, FORCE drains one load.
  typedef enum logic [0:0] {
    WB_NORMAL = 1'b0,
    WB_FORCE  = 1'b1
  } wb_state_t;

  // One register-file write request.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/wb_ld_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_ld_fifo
//  Description : Synchronous load-result FIFO for the writeback arbiter.
//                Power-of-two depth; read/write pointers wrap naturally.
//                A push while full and a pop while empty are both ignored,
//                so the occupancy count can neither overflow nor underflow.
//                The head is read from the registered storage only, so an
//                entry written this cycle is never visible to a same-cycle pop.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                push_i/push_data_i - write request and payload
//                pop_i            - remove head entry
//                head_o           - current head entry (valid when !empty_o)
//                full_o/empty_o   - occupancy flags
//                count_o          - occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_ld_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  wb_req_t                    push_data_i,
  input  logic                       pop_i,
  output wb_req_t                    head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               push_eff;
  logic               pop_eff;

  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign head_o   = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign push_eff = push_i && !full_o;
  assign pop_eff  = pop_i  && !empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule : wb_ld_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Writeback-side driver of the register-file write port.
//                Merges single-cycle ALU results with buffered load results.
//                The ALU normally has priority; a starvation counter forces
//                one load drain (stalling the ALU for a cycle) after
//                STARVE_LIMIT consecutive ALU wins over a pending load.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                alu_valid/alu_rd/alu_data  - ALU result
//                alu_stall                  - ALU must re-present its result
//                ld_valid/ld_rd/ld_data     - offered load result
//                ld_ready                   - load FIFO not full
//                reg_write/rd/write_data    - registered register-file write
//                ld_count                   - load FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import riscv_pkg::*;
#(
  // Must equal riscv_pkg::XLEN; the FIFO record is sized from the package.
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int LD_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [REG_ADDR_W-1:0]      alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  output logic                       alu_stall,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [REG_ADDR_W-1:0]      ld_rd,
  input  logic [XLEN-1:0]            ld_data,
  output logic                       reg_write,
  output logic [REG_ADDR_W-1:0]      rd,
  output logic [XLEN-1:0]            write_data,
  output logic [$clog2(LD_DEPTH):0]  ld_count
);

  // Wide enough to hold STARVE_LIMIT-1 for every legal limit (>=1).
  localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;

  // --------------------------------------------------------------------------
  // Load-result FIFO
  // --------------------------------------------------------------------------
  wb_req_t                   fifo_in;
  wb_req_t                   fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [$clog2(LD_DEPTH):0] fifo_count;

  assign fifo_in.rd   = ld_rd;
  assign fifo_in.data = ld_data;
  assign fifo_push    = ld_valid && !fifo_full;

  wb_ld_fifo #(
    .DEPTH (LD_DEPTH)
  ) u_ld_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign ld_ready = !fifo_full;
  assign ld_count = fifo_count;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  wb_state_t              state_q;
  logic [STARVE_W-1:0]    starve_q;
  logic                   alu_stall_q;
  logic                   reg_write_q;
  logic [REG_ADDR_W-1:0]  rd_q;
  logic [XLEN-1:0]        wdata_q;

  // --------------------------------------------------------------------------
  // Candidate selection
  // --------------------------------------------------------------------------
  logic     alu_win;
  logic     sel_valid;
  wb_req_t  sel;
  logic     write_en_d;

  always_comb begin
    alu_win   = 1'b0;
    fifo_pop  = 1'b0;
    sel       = fifo_head;
    if (state_q == WB_NORMAL && alu_valid) begin
      alu_win  = 1'b1;
      sel.rd   = alu_rd;
      sel.data = alu_data;
    end else if (!fifo_empty) begin
      // Covers both an idle ALU in NORMAL and the forced drain in FORCE.
      fifo_pop = 1'b1;
    end
    sel_valid  = alu_win || fifo_pop;
    // x0 requests are consumed but never reach the register file.
    write_en_d = sel_valid && (sel.rd != '0);
  end

  // --------------------------------------------------------------------------
  // Starvation FSM and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WB_NORMAL;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
    end else begin
      reg_write_q <= write_en_d;
      // Address/data hold across idle cycles and x0 requests.
      if (write_en_d) begin
        rd_q    <= sel.rd;
        wdata_q <= sel.data;
      end

      unique case (state_q)
        WB_NORMAL: begin
          if (alu_win && !fifo_empty) begin
            if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
              state_q     <= WB_FORCE;
              alu_stall_q <= 1'b1;
              starve_q    <= '0;
            end else begin
              starve_q    <= starve_q + STARVE_W'(1);
            end
          end else begin
            // A load was popped or nothing is waiting.
            starve_q <= '0;
          end
        end
        WB_FORCE: begin
          state_q     <= WB_NORMAL;
          alu_stall_q <= 1'b0;
          starve_q    <= '0;
        end
        default: begin
          state_q     <= WB_NORMAL;
          alu_stall_q <= 1'b0;
          starve_q    <= '0;
        end
      endcase
    end
  end

  assign alu_stall  = alu_stall_q;
  assign reg_write  = reg_write_q;
  assign rd         = rd_q;
  assign write_data = wdata_q;

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter. Directed scenarios
//                followed by randomized traffic, all checked against a
//                queue-based reference of the writeback rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int XW    = 64;
  localparam int DEPTH = 4;
  localparam int LIMIT = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [XW-1:0] alu_data;
  logic          alu_stall;
  logic          ld_valid;
  logic          ld_ready;
  logic [4:0]    ld_rd;
  logic [XW-1:0] ld_data;
  logic          reg_write;
  logic [4:0]    rd;
  logic [XW-1:0] write_data;
  logic [CW-1:0] ld_count;

  always #5 clk = ~clk;

  wb_arbiter #(
    .XLEN         (XW),
    .LD_DEPTH     (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .reg_write  (reg_write),
    .rd         (rd),
    .write_data (write_data),
    .ld_count   (ld_count)
  );

  // Reference model: pending loads in acceptance order plus starvation bookkeeping.
  typedef struct {
    logic [4:0]    rd;
    logic [XW-1:0] data;
  } ld_t;

  ld_t           mq[$];
  bit            m_force;
  int            m_starve;
  logic          m_we;
  logic [4:0]    m_rd;
  logic [XW-1:0] m_data;

  int tests  = 0;
  int failed = 0;
  bit alu_taken;
  bit ld_taken;

  task automatic chk(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_force  = 1'b0;
    m_starve = 0;
    m_we     = 1'b0;
    m_rd     = '0;
    m_data   = '0;
  endtask

  // One clock cycle with the inputs currently driven; model advanced and checked.
  task automatic step();
    bit   ready, win, nonempty;
    ld_t  h;
    ready = (mq.size() != DEPTH);
    chk("ld_ready", XW'(ld_ready), XW'(ready));
    alu_taken = 1'b0;
    ld_taken  = 1'b0;
    if (reset) begin
      model_clear();
    end else begin
      nonempty = (mq.size() != 0);
      win      = alu_valid && !m_force;
      if (win) begin
        m_we = (alu_rd != 0);
        if (alu_rd != 0) begin m_rd = alu_rd; m_data = alu_data; end
      end else if (nonempty) begin
        h    = mq.pop_front();
        m_we = (h.rd != 0);
        if (h.rd != 0) begin m_rd = h.rd; m_data = h.data; end
      end else begin
        m_we = 1'b0;
      end
      if (m_force) begin
        m_force  = 1'b0;
        m_starve = 0;
      end else if (win && nonempty) begin
        m_starve++;
        if (m_starve == LIMIT) begin
          m_force  = 1'b1;
          m_starve = 0;
        end
      end else begin
        m_starve = 0;
      end
      if (ld_valid && ready) begin
        mq.push_back('{rd: ld_rd, data: ld_data});
        ld_taken = 1'b1;
      end
      alu_taken = win;
    end
    @(posedge clk);
    #1;
    chk("reg_write",  XW'(reg_write), XW'(m_we));
    chk("rd",         XW'(rd),        XW'(m_rd));
    chk("write_data", write_data,     m_data);
    chk("alu_stall",  XW'(alu_stall), XW'(m_force));
    chk("ld_count",   XW'(ld_count),  XW'(mq.size()));
  endtask

  function automatic logic [4:0] rand_rd();
    return ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
  endfunction

  task automatic rand_cycle(input int p_alu, input int p_ld);
    reset = ($urandom_range(249) == 0);
    if (!alu_valid || alu_taken) begin
      alu_valid = ($urandom_range(99) < p_alu);
      alu_rd    = rand_rd();
      alu_data  = {$urandom, $urandom};
    end
    if (!ld_valid || ld_taken) begin
      ld_valid = ($urandom_range(99) < p_ld);
      ld_rd    = rand_rd();
      ld_data  = {$urandom, $urandom};
    end
    step();
  endtask

  initial begin
    int n_stall, n_acc, n_we;
    bit saw_full, saw_ld;

    reset     = 1'b1;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_rd     = '0;
    ld_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("rst_reg_write",  XW'(reg_write),  '0);
    chk("rst_rd",         XW'(rd),         '0);
    chk("rst_write_data", write_data,      '0);
    chk("rst_alu_stall",  XW'(alu_stall),  '0);
    chk("rst_ld_count",   XW'(ld_count),   '0);
    chk("rst_ld_ready",   XW'(ld_ready),   XW'(1));
    reset = 1'b0;

    // ALU result written one cycle later.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD;
    step();
    chk("t1_we",   XW'(reg_write), XW'(1));
    chk("t1_rd",   XW'(rd),        XW'(5));
    chk("t1_data", write_data,     64'hDEAD);

    // x0 destination: no write, address/data hold.
    alu_rd = 5'd0; alu_data = 64'hBEEF;
    step();
    chk("t2_we",   XW'(reg_write), XW'(0));
    chk("t2_rd",   XW'(rd),        XW'(5));
    chk("t2_data", write_data,     64'hDEAD);

    // Single load with the ALU idle: accepted, then written the cycle after.
    alu_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'h1234;
    step();
    chk("t3_count1", XW'(ld_count),  XW'(1));
    chk("t3_we0",    XW'(reg_write), XW'(0));
    ld_valid = 1'b0;
    step();
    chk("t3_we",     XW'(reg_write), XW'(1));
    chk("t3_rd",     XW'(rd),        XW'(7));
    chk("t3_data",   write_data,     64'h1234);
    chk("t3_count0", XW'(ld_count),  XW'(0));

    // Continuous ALU with one queued load: exactly one forced drain.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h100;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h99;
    step();
    ld_valid = 1'b0;
    n_stall = 0; saw_ld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (alu_taken) alu_data = alu_data + 1;
      step();
      if (alu_stall === 1'b1) n_stall++;
      if (reg_write === 1'b1 && rd === 5'd9 && write_data === 64'h99) saw_ld = 1'b1;
    end
    chk("t5_stall_cycles", XW'(n_stall), XW'(1));
    chk("t5_load_written", XW'(saw_ld),  XW'(1));

    // Continuous ALU, five loads: FIFO fills to four, fifth waits.
    saw_full = 1'b0; n_acc = 0;
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 64'hA0;
    for (int i = 0; i < 40 && n_acc < 5; i++) begin
      step();
      if (ld_count === CW'(DEPTH) && ld_ready === 1'b0) saw_full = 1'b1;
      if (alu_taken) alu_data = alu_data + 1;
      if (ld_taken) begin
        n_acc++;
        ld_rd   = ld_rd + 5'd1;
        ld_data = ld_data + 1;
        if (n_acc == 5) ld_valid = 1'b0;
      end
    end
    chk("t4_full_seen", XW'(saw_full), XW'(1));
    chk("t4_accepted",  XW'(n_acc),    XW'(5));
    alu_valid = 1'b0;
    repeat (8) step();

    // Three buffered loads discarded by a mid-operation reset.
    alu_valid = 1'b1; alu_rd = 5'd3;
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 64'hC0;
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 3; i++) begin
      step();
      if (alu_taken) alu_data = alu_data + 1;
      if (ld_taken) begin n_acc++; ld_rd = ld_rd + 5'd1; ld_data = ld_data + 1; end
    end
    chk("t6_count3", XW'(ld_count), XW'(3));
    ld_valid = 1'b0; alu_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_count0",    XW'(ld_count),  XW'(0));
    chk("t6_ready",     XW'(ld_ready),  XW'(1));
    chk("t6_reg_write", XW'(reg_write), XW'(0));
    chk("t6_alu_stall", XW'(alu_stall), XW'(0));
    n_we = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (reg_write === 1'b1) n_we++;
    end
    chk("t6_no_writes", XW'(n_we), XW'(0));

    // Randomized traffic in three load/ALU mixes.
    alu_valid = 1'b0; ld_valid = 1'b0;
    for (int i = 0; i < 300; i++) rand_cycle(90, 80);
    for (int i = 0; i < 300; i++) rand_cycle(30, 90);
    for (int i = 0; i < 300; i++) rand_cycle(60, 40);
    reset = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_wb_arbiter
`default_nettype wire
